// File: rtl/md_issue_ctrl_if.sv
// md_issue_ctrl_if: pipeline/muldiv handshake bundle; master = pipeline+unit side, slave = issue controller
interface md_issue_ctrl_if;
  logic [31:0] instr_d;
  logic [31:0] instr_e;
  logic        md_start;
  logic        md_busy;
  logic        md_stall;
  logic        md_occupied;
  logic [2:0]  md_err;
  logic [31:0] stall_cnt;
  modport master (
    output instr_d, instr_e, md_start, md_busy,
    input  md_stall, md_occupied, md_err, stall_cnt
  );
  modport slave (
    input  instr_d, instr_e, md_start, md_busy,
    output md_stall, md_occupied, md_err, stall_cnt
  );
endinterface

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: issues mult/div to the HI/LO unit, shadows its occupancy, stalls HI/LO ops in D; ports clk, reset, md (instr_d/instr_e/md_start/md_busy in, md_stall/md_occupied/md_err/stall_cnt out)
module md_issue_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int WDOG        = 16
) (
  input logic          clk,
  input logic          reset,
  md_issue_ctrl_if.slave md
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam int WW = $clog2(WDOG + 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [WW-1:0] wd;
  logic          is_div;
  logic          md_op_e, hl_op_e, hl_op_d, issue_e;
  function automatic logic md_op(input logic [31:0] i);
    return i[31:26] == 6'd0 && i[5:2] == 4'b0110;
  endfunction
  function automatic logic hl_op(input logic [31:0] i);
    return i[31:26] == 6'd0 && (i[5:2] == 4'b0110 || i[5:2] == 4'b0100);
  endfunction
  always_comb begin
    md_op_e = md_op(md.instr_e);
    hl_op_e = hl_op(md.instr_e);
    hl_op_d = hl_op(md.instr_d);
    issue_e = md_op_e && state == IDLE;
    md.md_stall = hl_op_d && (issue_e || state != IDLE || md.md_start || md.md_busy);
    md.md_occupied = state != IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      wd           <= '0;
      is_div       <= 1'b0;
      md.md_err    <= '0;
      md.stall_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (issue_e) begin
          state  <= ISSUE;
          is_div <= md.instr_e[1];
          cnt    <= md.instr_e[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          wd     <= '0;
        end
        ISSUE: begin
          state <= RUN;
          if (!md.md_start) md.md_err[0] <= 1'b1;
        end
        RUN: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= DRAIN;
        end
        default: if (!md.md_busy) state <= IDLE;
        else if (wd == WW'(WDOG - 1)) begin
          md.md_err[1] <= 1'b1;
          state        <= IDLE;
        end else wd <= wd + WW'(1);
      endcase
      if (state != IDLE && hl_op_e) md.md_err[2] <= 1'b1;
      if (md.md_stall && !(&md.stall_cnt)) md.stall_cnt <= md.stall_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb_md_issue_ctrl: scoreboard bench for md_issue_ctrl
module tb_md_issue_ctrl;
  localparam logic [31:0] NOP     = 32'h0000_0000;
  localparam logic [31:0] MULT    = 32'h0085_0018;
  localparam logic [31:0] DIV     = 32'h0085_001A;
  localparam logic [31:0] MFLO    = 32'h0000_4012;
  localparam logic [31:0] MFHI    = 32'h0000_4010;
  localparam logic [31:0] MTLO    = 32'h0080_0013;
  localparam logic [31:0] NR_MULT = 32'h0485_0018;
  typedef struct { string tag; logic [31:0] v; } exp_t;
  exp_t sb[$];
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  int st, oc;
  md_issue_ctrl_if md ();
  md_issue_ctrl dut (.clk(clk), .reset(reset), .md(md));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.v = v;
    sb.push_back(e);
  endtask
  task automatic pop_check(input logic [31:0] got);
    exp_t e;
    if (sb.size() == 0) check("sb_empty", got, 32'hDEAD_BEEF);
    else begin
      e = sb.pop_front();
      check(e.tag, got, e.v);
    end
  endtask
  task automatic idle_in();
    md.instr_e = NOP;
    md.instr_d = NOP;
    md.md_start = 1'b0;
    md.md_busy = 1'b0;
  endtask
  task automatic run_md(input logic [31:0] op, input logic [31:0] d0, input logic [31:0] dn,
                        input logic [31:0] fop, input int fk, input int nbusy, input bit give_start,
                        output int stalls, output int occ);
    stalls = 0;
    occ = 0;
    for (int k = 0; k < 40; k++) begin
      md.instr_e = k == 0 ? op : (k == fk ? fop : NOP);
      md.instr_d = k == 0 ? d0 : dn;
      md.md_start = give_start && k == 1;
      md.md_busy = k >= 2 && k < 2 + nbusy;
      @(negedge clk);
      stalls += int'(md.md_stall);
      occ += int'(md.md_occupied);
      @(posedge clk);
      #1;
    end
    idle_in();
  endtask
  initial begin
    idle_in();
    #12;
    push("rst_occ", 0); push("rst_err", 0); push("rst_cnt", 0); push("rst_stall", 0);
    pop_check(32'(md.md_occupied)); pop_check(32'(md.md_err));
    pop_check(md.stall_cnt); pop_check(32'(md.md_stall));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    push("mult_stall", 7); push("mult_occ", 7); push("mult_err", 0); push("mult_cnt", 7);
    run_md(MULT, NOP, MFLO, NOP, -1, 5, 1'b1, st, oc);
    pop_check(32'(st)); pop_check(32'(oc)); pop_check(32'(md.md_err)); pop_check(md.stall_cnt);
    push("div_stall", 12); push("div_occ", 12); push("div_cnt", 19);
    run_md(DIV, NOP, MFHI, NOP, -1, 10, 1'b1, st, oc);
    pop_check(32'(st)); pop_check(32'(oc)); pop_check(md.stall_cnt);
    push("simul_stall", 8); push("simul_occ", 7); push("simul_cnt", 27);
    run_md(MULT, MFLO, MFLO, NOP, -1, 5, 1'b1, st, oc);
    pop_check(32'(st)); pop_check(32'(oc)); pop_check(md.stall_cnt);
    push("nonr_stall", 0); push("nonr_occ", 0); push("nonr_err", 0);
    run_md(NR_MULT, MFLO, MFLO, NOP, -1, 0, 1'b0, st, oc);
    pop_check(32'(st)); pop_check(32'(oc)); pop_check(32'(md.md_err));
    push("nostart_occ", 7); push("nostart_err", 3'b001); push("nostart_idle", 0);
    run_md(MULT, NOP, NOP, NOP, -1, 0, 1'b0, st, oc);
    pop_check(32'(oc)); pop_check(32'(md.md_err)); pop_check(32'(md.md_occupied));
    push("wdog_occ", 22); push("wdog_err", 3'b011); push("wdog_idle", 0);
    run_md(MULT, NOP, NOP, NOP, -1, 100, 1'b1, st, oc);
    pop_check(32'(oc)); pop_check(32'(md.md_err)); pop_check(32'(md.md_occupied));
    push("mtlo_occ", 7); push("mtlo_err", 3'b111);
    run_md(MULT, NOP, NOP, MTLO, 4, 5, 1'b1, st, oc);
    pop_check(32'(oc)); pop_check(32'(md.md_err));
    push("reissue_occ", 7);
    run_md(MULT, NOP, NOP, MULT, 4, 5, 1'b1, st, oc);
    pop_check(32'(oc));
    md.instr_e = DIV;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      md.instr_e = NOP;
      md.md_start = k == 0;
      md.md_busy = k >= 1;
    end
    #2;
    push("pre_rst_occ", 1);
    pop_check(32'(md.md_occupied));
    reset = 1'b1;
    #1;
    push("arst_occ", 0); push("arst_err", 0); push("arst_cnt", 0);
    pop_check(32'(md.md_occupied)); pop_check(32'(md.md_err)); pop_check(md.stall_cnt);
    md.instr_d = MFHI;
    #1;
    push("arst_stall_busy", 1);
    pop_check(32'(md.md_stall));
    md.md_busy = 1'b0;
    #1;
    push("arst_stall_idle", 0);
    pop_check(32'(md.md_stall));
    idle_in();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    push("post_stall", 7); push("post_occ", 7); push("post_err", 0); push("post_cnt", 7);
    run_md(MULT, NOP, MFLO, NOP, -1, 5, 1'b1, st, oc);
    pop_check(32'(st)); pop_check(32'(oc)); pop_check(32'(md.md_err)); pop_check(md.stall_cnt);
    if (sb.size() != 0) check("sb_left", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
